// File: rtl/pipe_ctrl_pkg.sv
// Shared pipeline-control types for the 5-stage core (sequencer and forwarding unit).
// Holds the mult/div occupancy state enum, register-address width and control bundle.
package pipe_ctrl_pkg;

  localparam int REG_AW = 5;

  typedef enum logic [0:0] {
    RUN     = 1'b0,
    MD_BUSY = 1'b1
  } md_state_e;

  typedef struct packed {
    logic pc_write;
    logic ifid_write;
    logic ifid_flush;
    logic idex_flush;
  } pipe_ctl_t;

  function automatic pipe_ctl_t mk_ctl(input logic pc_write, input logic ifid_write,
                                       input logic ifid_flush, input logic idex_flush);
    pipe_ctl_t c;
    c.pc_write   = pc_write;
    c.ifid_write = ifid_write;
    c.ifid_flush = ifid_flush;
    c.idex_flush = idex_flush;
    return c;
  endfunction

  localparam pipe_ctl_t CTL_RESET  = '{pc_write: 1'b0, ifid_write: 1'b0, ifid_flush: 1'b1, idex_flush: 1'b1};
  localparam pipe_ctl_t CTL_BRANCH = '{pc_write: 1'b1, ifid_write: 1'b1, ifid_flush: 1'b1, idex_flush: 1'b1};
  localparam pipe_ctl_t CTL_STALL  = '{pc_write: 1'b0, ifid_write: 1'b0, ifid_flush: 1'b0, idex_flush: 1'b1};
  localparam pipe_ctl_t CTL_JUMP   = '{pc_write: 1'b1, ifid_write: 1'b1, ifid_flush: 1'b1, idex_flush: 1'b0};
  localparam pipe_ctl_t CTL_RUN    = '{pc_write: 1'b1, ifid_write: 1'b1, ifid_flush: 1'b0, idex_flush: 1'b0};

endpackage

// File: rtl/pipe_hazard_ctrl_md_occ_counter.sv
// Loadable down-counter tracking remaining mult/div EX occupancy cycles.
// zero flags the final occupancy cycle; the counter never wraps below zero.
module md_occ_counter #(
  parameter int MD_LATENCY = 4,
  parameter int CW         = $clog2(MD_LATENCY)
) (
  input  logic          clk_i,
  input  logic          rst_n,
  input  logic          load,
  input  logic          dec,
  output logic [CW-1:0] cnt,
  output logic          zero
);

  localparam logic [CW-1:0] LOAD_VAL = CW'(MD_LATENCY - 1);

  logic [CW-1:0] cnt_r;

  // Occupancy count: load on issue, step down while busy.
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= {CW{1'b0}};
    end else if (load) begin
      cnt_r <= LOAD_VAL;
    end else if (dec && (cnt_r != {CW{1'b0}})) begin
      cnt_r <= cnt_r - {{(CW-1){1'b0}}, 1'b1};
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign cnt  = cnt_r;
  assign zero = (cnt_r == {CW{1'b0}});

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencer: load-use, branch, jump and mult/div hazard control for the MIPS core.
// Optional PIPE_HAZ_PERF_EN adds saturating stall/flush performance counters.
module pipe_hazard_ctrl #(
  parameter int MD_LATENCY = 4,
  parameter int REG_AW     = pipe_ctrl_pkg::REG_AW
) (
  input  logic              clk_i,
  input  logic              rst_n,
  input  logic [REG_AW-1:0] id_rs_i,
  input  logic [REG_AW-1:0] id_rt_i,
  input  logic              id_uses_rt_i,
  input  logic              id_md_use_i,
  input  logic              id_jump_i,
  input  logic [REG_AW-1:0] ex_rt_i,
  input  logic              ex_memread_i,
  input  logic              ex_br_taken_i,
  input  logic              ex_md_start_i,
  output logic              pc_write_o,
  output logic              ifid_write_o,
  output logic              ifid_flush_o,
  output logic              idex_flush_o,
  output logic              md_busy_o,
  output logic              md_done_o
`ifdef PIPE_HAZ_PERF_EN
  ,
  output logic [31:0]       stall_cnt_o,
  output logic [31:0]       flush_cnt_o
`endif
);

  import pipe_ctrl_pkg::*;

  localparam int CW = $clog2(MD_LATENCY);

  md_state_e     state_r;
  md_state_e     state_s;
  logic          load_s;
  logic          busy_s;
  logic          cnt_zero_s;
  logic [CW-1:0] cnt_s;
  logic          lu_s;
  logic          mds_s;
  pipe_ctl_t     ctl_s;

  md_occ_counter #(
    .MD_LATENCY (MD_LATENCY),
    .CW         (CW)
  ) u_md_cnt (
    .clk_i (clk_i),
    .rst_n (rst_n),
    .load  (load_s),
    .dec   (busy_s),
    .cnt   (cnt_s),
    .zero  (cnt_zero_s)
  );

  // Mult/div occupancy state register.
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= RUN;
    end else begin
      state_r <= state_s;
    end
  end

  // Next state; a new issue is ignored while the unit is still occupied.
  always_comb begin
    state_s = state_r;
    load_s  = 1'b0;
    case (state_r)
      RUN: begin
        if (ex_md_start_i) begin
          state_s = MD_BUSY;
          load_s  = 1'b1;
        end else begin
          state_s = RUN;
        end
      end
      MD_BUSY: begin
        if (cnt_zero_s) begin
          state_s = RUN;
        end else begin
          state_s = MD_BUSY;
        end
      end
      default: begin
        state_s = RUN;
      end
    endcase
  end

  assign busy_s = (state_r == MD_BUSY);

  assign lu_s = ex_memread_i && (ex_rt_i != {REG_AW{1'b0}}) &&
                ((ex_rt_i == id_rs_i) || (id_uses_rt_i && (ex_rt_i == id_rt_i)));
  assign mds_s = busy_s && !cnt_zero_s && id_md_use_i;

  // Priority mux; reset overrides combinationally so the pipe is held while rst_n is low.
  always_comb begin
    ctl_s = CTL_RUN;
    if (!rst_n) begin
      ctl_s = CTL_RESET;
    end else if (ex_br_taken_i) begin
      ctl_s = CTL_BRANCH;
    end else if (lu_s || mds_s) begin
      ctl_s = CTL_STALL;
    end else if (id_jump_i) begin
      ctl_s = CTL_JUMP;
    end else begin
      ctl_s = mk_ctl(1'b1, 1'b1, 1'b0, 1'b0);
    end
  end

  assign pc_write_o   = ctl_s.pc_write;
  assign ifid_write_o = ctl_s.ifid_write;
  assign ifid_flush_o = ctl_s.ifid_flush;
  assign idex_flush_o = ctl_s.idex_flush;
  assign md_busy_o    = busy_s;
  assign md_done_o    = busy_s && cnt_zero_s;

`ifdef PIPE_HAZ_PERF_EN
  logic [31:0] stall_cnt_r;
  logic [31:0] flush_cnt_r;

  // Saturating performance counters; reset cycles never reach the increment.
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_r <= 32'd0;
      flush_cnt_r <= 32'd0;
    end else begin
      if (!ctl_s.pc_write && (stall_cnt_r != 32'hFFFF_FFFF)) begin
        stall_cnt_r <= stall_cnt_r + 32'd1;
      end else begin
        stall_cnt_r <= stall_cnt_r;
      end
      if (ctl_s.ifid_flush && (flush_cnt_r != 32'hFFFF_FFFF)) begin
        flush_cnt_r <= flush_cnt_r + 32'd1;
      end else begin
        flush_cnt_r <= flush_cnt_r;
      end
    end
  end

  assign stall_cnt_o = stall_cnt_r;
  assign flush_cnt_o = flush_cnt_r;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: directed scenarios then random traffic.
// Expected outputs come from a cycle-count reference model of the hazard rules.
module tb_pipe_hazard_ctrl;

  localparam int MD_LATENCY = 4;
  localparam int REG_AW     = 5;

  logic              clk_i;
  logic              rst_n;
  logic [REG_AW-1:0] id_rs_i;
  logic [REG_AW-1:0] id_rt_i;
  logic              id_uses_rt_i;
  logic              id_md_use_i;
  logic              id_jump_i;
  logic [REG_AW-1:0] ex_rt_i;
  logic              ex_memread_i;
  logic              ex_br_taken_i;
  logic              ex_md_start_i;
  logic              pc_write_o;
  logic              ifid_write_o;
  logic              ifid_flush_o;
  logic              idex_flush_o;
  logic              md_busy_o;
  logic              md_done_o;
`ifdef PIPE_HAZ_PERF_EN
  logic [31:0]       stall_cnt_o;
  logic [31:0]       flush_cnt_o;
`endif

  pipe_hazard_ctrl #(.MD_LATENCY(MD_LATENCY), .REG_AW(REG_AW)) dut (
    .clk_i         (clk_i),
    .rst_n         (rst_n),
    .id_rs_i       (id_rs_i),
    .id_rt_i       (id_rt_i),
    .id_uses_rt_i  (id_uses_rt_i),
    .id_md_use_i   (id_md_use_i),
    .id_jump_i     (id_jump_i),
    .ex_rt_i       (ex_rt_i),
    .ex_memread_i  (ex_memread_i),
    .ex_br_taken_i (ex_br_taken_i),
    .ex_md_start_i (ex_md_start_i),
    .pc_write_o    (pc_write_o),
    .ifid_write_o  (ifid_write_o),
    .ifid_flush_o  (ifid_flush_o),
    .idex_flush_o  (idex_flush_o),
    .md_busy_o     (md_busy_o),
    .md_done_o     (md_done_o)
`ifdef PIPE_HAZ_PERF_EN
    ,
    .stall_cnt_o   (stall_cnt_o),
    .flush_cnt_o   (flush_cnt_o)
`endif
  );

  typedef struct {
    logic [5:0]  outs;
    logic [31:0] sc;
    logic [31:0] fc;
    int          cyc;
  } exp_t;

  exp_t        q[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  int          cyc     = 0;
  int          busy_left = 0;
  logic [31:0] m_stall = 32'd0;
  logic [31:0] m_flush = 32'd0;

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // One stimulus cycle: apply inputs after the edge, push the model's expectation.
  task automatic drive(input logic rst, input logic [4:0] rs, input logic [4:0] rt,
                       input logic urt, input logic mdu, input logic jmp,
                       input logic [4:0] ert, input logic mr, input logic bt, input logic st);
    exp_t e;
    logic lu, mds;
    logic pc, iw, ifl, idl, bz, dn;
    @(posedge clk_i);
    #1;
    rst_n = rst; id_rs_i = rs; id_rt_i = rt; id_uses_rt_i = urt; id_md_use_i = mdu;
    id_jump_i = jmp; ex_rt_i = ert; ex_memread_i = mr; ex_br_taken_i = bt; ex_md_start_i = st;
    cyc++;
    if (!rst) begin
      {pc, iw, ifl, idl, bz, dn} = 6'b001100;
      busy_left = 0;
      m_stall = 32'd0;
      m_flush = 32'd0;
      e.sc = 32'd0;
      e.fc = 32'd0;
    end else begin
      bz  = (busy_left > 0);
      dn  = (busy_left == 1);
      lu  = mr && (ert != 5'd0) && ((ert == rs) || (urt && (ert == rt)));
      mds = (busy_left > 1) && mdu;
      if (bt)              {pc, iw, ifl, idl} = 4'b1111;
      else if (lu || mds)  {pc, iw, ifl, idl} = 4'b0001;
      else if (jmp)        {pc, iw, ifl, idl} = 4'b1110;
      else                 {pc, iw, ifl, idl} = 4'b1100;
      e.sc = m_stall;
      e.fc = m_flush;
      if (!pc && m_stall != 32'hFFFF_FFFF) m_stall = m_stall + 32'd1;
      if (ifl && m_flush != 32'hFFFF_FFFF) m_flush = m_flush + 32'd1;
      if (busy_left > 0) busy_left = busy_left - 1;
      else if (st)       busy_left = MD_LATENCY;
    end
    e.outs = {pc, iw, ifl, idl, bz, dn};
    e.cyc  = cyc;
    q.push_back(e);
  endtask

  task automatic idle(input logic [4:0] rs, input logic mdu);
    drive(1'b1, rs, 5'd0, 1'b0, mdu, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
  endtask

  // Monitor: outputs are settled mid-cycle, compare against the oldest expectation.
  always begin : mon
    exp_t e;
    logic [5:0] got;
    @(negedge clk_i);
    if (q.size() > 0) begin
      e = q.pop_front();
      got = {pc_write_o, ifid_write_o, ifid_flush_o, idex_flush_o, md_busy_o, md_done_o};
      n_tests++;
      if (got !== e.outs) begin
        n_fail++;
        $display("FAIL ctl cycle %0d: got pc/iw/ifl/idl/busy/done=%b expected %b", e.cyc, got, e.outs);
      end
`ifdef PIPE_HAZ_PERF_EN
      n_tests++;
      if (stall_cnt_o !== e.sc || flush_cnt_o !== e.fc) begin
        n_fail++;
        $display("FAIL perf cycle %0d: got stall=%0d flush=%0d expected stall=%0d flush=%0d",
                 e.cyc, stall_cnt_o, flush_cnt_o, e.sc, e.fc);
      end
`endif
    end
  end

  initial begin
    rst_n = 1'b0; id_rs_i = '0; id_rt_i = '0; id_uses_rt_i = 1'b0; id_md_use_i = 1'b0;
    id_jump_i = 1'b0; ex_rt_i = '0; ex_memread_i = 1'b0; ex_br_taken_i = 1'b0; ex_md_start_i = 1'b0;

    repeat (3) drive(1'b0, 5'd3, 5'd3, 1'b1, 1'b1, 1'b1, 5'd3, 1'b1, 1'b0, 1'b0);

    // Load-use on rs: one bubble, then the load has moved on.
    drive(1'b1, 5'd3, 5'd1, 1'b0, 1'b0, 1'b0, 5'd3, 1'b1, 1'b0, 1'b0);
    idle(5'd3, 1'b0);
    // Load-use on rt only when rt is a source.
    drive(1'b1, 5'd1, 5'd4, 1'b1, 1'b0, 1'b0, 5'd4, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 5'd1, 5'd4, 1'b0, 1'b0, 1'b0, 5'd4, 1'b1, 1'b0, 1'b0);
    // Load to $0 never stalls.
    drive(1'b1, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0);
    // Mult/div issue then mfhi waiting in ID.
    drive(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
    repeat (MD_LATENCY) idle(5'd0, 1'b1);
    idle(5'd0, 1'b1);
    // Taken branch beats load-use and jump.
    drive(1'b1, 5'd2, 5'd0, 1'b0, 1'b0, 1'b1, 5'd2, 1'b1, 1'b1, 1'b0);
    // Jump held by load-use, flushed once the stall clears.
    drive(1'b1, 5'd2, 5'd0, 1'b0, 1'b0, 1'b1, 5'd2, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 5'd2, 5'd0, 1'b0, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
    // Reset on the second busy cycle aborts the operation.
    drive(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
    idle(5'd0, 1'b1);
    drive(1'b0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    repeat (2) idle(5'd0, 1'b1);

    for (int i = 0; i < 3000; i++) begin
      drive(($urandom_range(0, 199) != 0),
            5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 1'($urandom),
            1'($urandom), ($urandom_range(0, 7) == 0),
            5'($urandom_range(0, 3)), 1'($urandom), ($urandom_range(0, 9) == 0),
            ($urandom_range(0, 5) == 0));
    end

    idle(5'd0, 1'b0);
    repeat (3) @(posedge clk_i);
    n_tests++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending expectations, expected 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
